// File: rtl/mem_arbiter.sv
// Two-requester (ICache/DCache) arbiter in front of a single-outstanding memory port.
// DCache has priority, but an ICache request waiting behind three DCache grants wins next.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_W-1:0]     ic_req_addr,
  output logic                  ic_resp_valid,

  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic                  dc_req_rw,
  input  logic [ADDR_W-1:0]     dc_req_addr,
  input  logic [DATA_W-1:0]     dc_req_data,
  input  logic [DATA_W/8-1:0]   dc_req_mask,
  output logic                  dc_resp_valid,

  output logic [DATA_W-1:0]     resp_data,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic [DATA_W/8-1:0]   mem_req_mask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          dc_streak_q, dc_streak_d;
  logic                src_ic_q;
  logic                req_valid_q;
  logic                req_rw_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_data_q;
  logic [MASK_W-1:0]   req_mask_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                ic_resp_q;
  logic                dc_resp_q;

  logic grant_ic;
  logic grant_dc;
  logic in_idle;
  logic req_done;
  logic resp_done;

  assign in_idle   = (state_q == StIdle);
  assign grant_ic  = in_idle && ic_req_valid && (!dc_req_valid || (dc_streak_q == 2'd3));
  assign grant_dc  = in_idle && dc_req_valid && !grant_ic;
  assign req_done  = (state_q == StReq) && mem_req_ready;
  assign resp_done = (state_q == StResp) && mem_resp_valid;

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign ic_req_ready = reset && grant_ic;
  assign dc_req_ready = reset && grant_dc;

  always_comb begin
    state_d     = state_q;
    dc_streak_d = dc_streak_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ic || grant_dc) begin
          state_d = StReq;
        end
        if (grant_ic) begin
          dc_streak_d = 2'd0;
        end else if (grant_dc && ic_req_valid && (dc_streak_q != 2'd3)) begin
          dc_streak_d = dc_streak_q + 2'd1;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = req_rw_q ? StIdle : StResp;
        end
      end
      StResp: begin
        if (mem_resp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dc_streak_q <= 2'd0;
      src_ic_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_mask_q  <= '0;
      resp_data_q <= '0;
      ic_resp_q   <= 1'b0;
      dc_resp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dc_streak_q <= dc_streak_d;
      ic_resp_q   <= 1'b0;
      dc_resp_q   <= 1'b0;
      if (grant_ic || grant_dc) begin
        src_ic_q    <= grant_ic;
        req_valid_q <= 1'b1;
        req_rw_q    <= grant_dc && dc_req_rw;
        req_addr_q  <= grant_ic ? ic_req_addr : dc_req_addr;
        req_data_q  <= grant_ic ? '0 : dc_req_data;
        // Reads always enable every byte, whoever issued them.
        req_mask_q  <= (grant_dc && dc_req_rw) ? dc_req_mask : '1;
      end else if (req_done) begin
        req_valid_q <= 1'b0;
      end
      if (resp_done) begin
        resp_data_q <= mem_resp_data;
        ic_resp_q   <= src_ic_q;
        dc_resp_q   <= !src_ic_q;
      end
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_data_q;
  assign mem_req_mask  = req_mask_q;
  assign resp_data     = resp_data_q;
  assign ic_resp_valid = ic_resp_q;
  assign dc_resp_valid = dc_resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven single transactions plus arbitration,
// spurious-response and reset sequences; read data checked through a scoreboard queue.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_data;
  logic [MW-1:0] dc_req_mask;
  logic [DW-1:0] resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [MW-1:0] mem_req_mask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask),
    .dc_resp_valid(dc_resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          is_ic;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    int            rd_wait;    // cycles mem_req_ready held low
    int            resp_wait;  // RESP cycles before mem_resp_valid
    logic [DW-1:0] rdata;
    logic          exp_rw;
    logic [MW-1:0] exp_mask;
    logic [DW-1:0] exp_data;
    int            exp_lat;    // accept-to-resp_valid cycles, 0 = no pulse
  } vec_t;

  typedef struct {
    logic          src_ic;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk_no_pulse(input string name);
    chk({name, "_ic"}, {127'b0, ic_resp_valid}, '0);
    chk({name, "_dc"}, {127'b0, dc_resp_valid}, '0);
  endtask

  // Called in the cycle a response pulse is due; pops the scoreboard.
  task automatic check_resp(input string name, input int t0, input int exp_lat);
    exp_t e;
    if (!(ic_resp_valid || dc_resp_valid)) begin
      total++;
      bad++;
      $display("FAIL %s: got no resp_valid pulse want one", name);
    end else if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unexpected resp_valid want none", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_ic_valid"}, {127'b0, ic_resp_valid}, {127'b0, e.src_ic});
      chk({name, "_dc_valid"}, {127'b0, dc_resp_valid}, {127'b0, !e.src_ic});
      chk({name, "_data"}, resp_data, e.data);
      if (exp_lat > 0) chk({name, "_latency"}, DW'(cyc - t0), DW'(exp_lat));
    end
  endtask

  task automatic do_txn(input int k);
    vec_t v;
    int   t0;
    v = vecs[k];
    ic_req_valid = v.is_ic;
    ic_req_addr  = v.addr;
    dc_req_valid = !v.is_ic;
    dc_req_rw    = v.rw;
    dc_req_addr  = v.addr;
    dc_req_data  = v.data;
    dc_req_mask  = v.mask;
    #1;
    chk($sformatf("v%0d_ic_ready", k), {127'b0, ic_req_ready}, {127'b0, v.is_ic});
    chk($sformatf("v%0d_dc_ready", k), {127'b0, dc_req_ready}, {127'b0, !v.is_ic});
    t0 = cyc;
    tick();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    chk($sformatf("v%0d_ready_pulse", k), {126'b0, ic_req_ready, dc_req_ready}, '0);
    for (int i = 0; i <= v.rd_wait; i++) begin
      if (i == v.rd_wait) mem_req_ready = 1'b1;
      chk($sformatf("v%0d_mvalid_%0d", k, i), {127'b0, mem_req_valid}, {127'b0, 1'b1});
      chk($sformatf("v%0d_mrw_%0d", k, i), {127'b0, mem_req_rw}, {127'b0, v.exp_rw});
      chk($sformatf("v%0d_maddr_%0d", k, i), DW'(mem_req_addr), DW'(v.addr));
      chk($sformatf("v%0d_mmask_%0d", k, i), DW'(mem_req_mask), DW'(v.exp_mask));
      if (v.exp_rw) chk($sformatf("v%0d_mdata_%0d", k, i), mem_req_data, v.exp_data);
      tick();
    end
    mem_req_ready = 1'b0;
    chk($sformatf("v%0d_mvalid_after", k), {127'b0, mem_req_valid}, '0);
    if (v.exp_lat == 0) begin
      for (int i = 0; i < 3; i++) begin
        chk_no_pulse($sformatf("v%0d_wr_nopulse%0d", k, i));
        tick();
      end
    end else begin
      sb.push_back('{src_ic: v.is_ic, data: v.rdata});
      for (int i = 0; i < v.resp_wait; i++) begin
        chk_no_pulse($sformatf("v%0d_wait%0d", k, i));
        tick();
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = v.rdata;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = {4{32'hDEAD_BEEF}};
      check_resp($sformatf("v%0d_resp", k), t0, v.exp_lat);
      tick();
      chk_no_pulse($sformatf("v%0d_pulse_end", k));
      chk($sformatf("v%0d_data_hold", k), resp_data, v.rdata);
    end
  endtask

  initial begin
    logic [7:0]    order;
    logic          got_ic;
    int            n;

    // D,D,D,I,D,D,D,I expressed as 1 = ICache grant, g0 in bit 7.
    order = 8'b0001_0001;

    vecs[0] = '{1'b0, 1'b0, 28'h10, '0, 16'h0003, 0, 2, {16{8'hA5}},
                1'b0, 16'hFFFF, '0, 5};
    vecs[1] = '{1'b0, 1'b1, 28'h20, {4{32'h1234_5678}}, 16'h000F, 4, 0, '0,
                1'b1, 16'h000F, {4{32'h1234_5678}}, 0};
    vecs[2] = '{1'b1, 1'b0, 28'h1234, '0, 16'h0000, 1, 0, {8{16'hC0DE}},
                1'b0, 16'hFFFF, '0, 4};
    vecs[3] = '{1'b0, 1'b1, 28'h0FF_FFFF, {16{8'h3C}}, 16'hFFFF, 0, 0, '0,
                1'b1, 16'hFFFF, {16{8'h3C}}, 0};
    vecs[4] = '{1'b0, 1'b0, 28'hFFF_FFFF, '0, 16'h8001, 2, 3, {4{32'h0BAD_F00D}},
                1'b0, 16'hFFFF, '0, 8};

    reset          = 1'b0;
    ic_req_valid   = 1'b1;
    ic_req_addr    = 28'h1;
    dc_req_valid   = 1'b1;
    dc_req_rw      = 1'b1;
    dc_req_addr    = 28'h2;
    dc_req_data    = '1;
    dc_req_mask    = '1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = '1;
    tick();
    tick();
    chk("rst_readies", {126'b0, ic_req_ready, dc_req_ready}, '0);
    chk("rst_mem_valid", {127'b0, mem_req_valid}, '0);
    chk("rst_mem_mask", DW'(mem_req_mask), '0);
    chk("rst_resp", {126'b0, ic_resp_valid, dc_resp_valid}, '0);
    chk("rst_resp_data", resp_data, '0);
    ic_req_valid   = 1'b0;
    dc_req_valid   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    reset          = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) do_txn(k);

    // Both requesters held high: DCache streak of three, then one ICache grant.
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h400;
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b1;
    dc_req_addr  = 28'h800;
    dc_req_mask  = 16'h00FF;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (!ic_req_ready && !dc_req_ready && n < 10) begin
        tick();
        n++;
      end
      got_ic = ic_req_ready;
      chk($sformatf("arb_grant%0d", g), {127'b0, got_ic}, {127'b0, order[7-g]});
      chk($sformatf("arb_onehot%0d", g), {127'b0, ic_req_ready && dc_req_ready}, '0);
      if (order[7-g]) chk($sformatf("arb_streak3_%0d", g), DW'(dut.dc_streak_q), DW'(3));
      tick();
      if (got_ic) chk($sformatf("arb_streak_clr%0d", g), DW'(dut.dc_streak_q), '0);
      chk($sformatf("arb_mrw%0d", g), {127'b0, mem_req_rw}, {127'b0, !got_ic});
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      if (got_ic) begin
        sb.push_back('{src_ic: 1'b1, data: DW'(g + 32'h100)});
        mem_resp_valid = 1'b1;
        mem_resp_data  = DW'(g + 32'h100);
        tick();
        mem_resp_valid = 1'b0;
        check_resp($sformatf("arb_resp%0d", g), 0, 0);
      end
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    tick();

    // Spurious memory responses in IDLE and in REQ.
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hFACE_FACE}};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_no_pulse($sformatf("spur_idle%0d", i));
      chk($sformatf("spur_idle_mvalid%0d", i), {127'b0, mem_req_valid}, '0);
    end
    mem_resp_valid = 1'b0;
    dc_req_valid   = 1'b1;
    dc_req_rw      = 1'b0;
    dc_req_addr    = 28'h77;
    #1;
    chk("spur_idle_still_idle", {127'b0, dc_req_ready}, {127'b0, 1'b1});
    tick();
    dc_req_valid   = 1'b0;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_no_pulse($sformatf("spur_req%0d", i));
      chk($sformatf("spur_req_mvalid%0d", i), {127'b0, mem_req_valid}, {127'b0, 1'b1});
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    sb.push_back('{src_ic: 1'b0, data: {4{32'h5555_AAAA}}});
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'h5555_AAAA}};
    tick();
    mem_resp_valid = 1'b0;
    check_resp("spur_resp", 0, 0);
    tick();

    // Reset while waiting in RESP; the late response must be dropped.
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b0;
    dc_req_addr  = 28'h55;
    tick();
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    dc_req_valid  = 1'b1;
    reset         = 1'b0;
    #1;
    chk("mid_rst_ready", {126'b0, ic_req_ready, dc_req_ready}, '0);
    chk("mid_rst_mvalid", {127'b0, mem_req_valid}, '0);
    chk("mid_rst_maddr", DW'(mem_req_addr), '0);
    chk("mid_rst_resp_data", resp_data, '0);
    chk("mid_rst_resp", {126'b0, ic_resp_valid, dc_resp_valid}, '0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'h7777_7777}};
    tick();
    dc_req_valid = 1'b0;
    reset        = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_no_pulse($sformatf("post_rst%0d", i));
      chk($sformatf("post_rst_data%0d", i), resp_data, '0);
      tick();
    end
    do_txn(0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, word-address width of all address ports.
REQ-002 Parameter DATA_W, default 128, width of every data port; mask width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ic_req_valid  input  1  ICache miss read request pending.
REQ-006 ic_req_ready  output  1  ICache request accepted this cycle.
REQ-007 ic_req_addr  input  ADDR_W  ICache read address.
REQ-008 ic_resp_valid  output  1  resp_data holds the ICache read data.
REQ-009 dc_req_valid  input  1  DCache request pending.
REQ-010 dc_req_ready  output  1  DCache request accepted this cycle.
REQ-011 dc_req_rw  input  1  1 = write, 0 = read.
REQ-012 dc_req_addr  input  ADDR_W  DCache address.
REQ-013 dc_req_data  input  DATA_W  DCache write data.
REQ-014 dc_req_mask  input  DATA_W/8  DCache byte write enables.
REQ-015 dc_resp_valid  output  1  resp_data holds the DCache read data.
REQ-016 resp_data  output  DATA_W  read data, shared by both requesters.
REQ-017 mem_req_valid  output  1  request to main memory valid.
REQ-018 mem_req_ready  input  1  main memory accepts the request.
REQ-019 mem_req_rw  output  1  1 = write, 0 = read.
REQ-020 mem_req_addr  output  ADDR_W  memory address.
REQ-021 mem_req_data  output  DATA_W  memory write data.
REQ-022 mem_req_mask  output  DATA_W/8  memory byte enables; all ones for reads.
REQ-023 mem_resp_valid  input  1  single-beat read response valid.
REQ-024 mem_resp_data  input  DATA_W  read response data.

Function
REQ-025 The FSM SHALL have three states: IDLE, REQ and RESP, with exactly one memory transaction outstanding at a time.
REQ-026 IDLE: if any req_valid is high, the block SHALL select a winner, drive that winner's req_ready high for that cycle only, latch the winner's rw/addr/data/mask and source, and go to REQ.
REQ-027 ic_req_ready and dc_req_ready SHALL be combinational, high only in IDLE, and never high together.
REQ-028 Arbitration: DCache wins by default; ICache wins when both are valid and dc_streak == 3.
REQ-029 dc_streak (2-bit) SHALL increment on a DCache grant while ic_req_valid is high, saturate at 3, and clear on any ICache grant.
REQ-030 ICache requests SHALL always be reads (mem_req_rw = 0, mask all ones).
REQ-031 REQ: mem_req_valid and mem_req_* SHALL be registered, driven from the latched values, and held stable until mem_req_ready.
REQ-032 REQ with mem_req_ready: a write SHALL go to IDLE; a read SHALL go to RESP.
REQ-033 RESP: on mem_resp_valid, the block SHALL register mem_resp_data into resp_data, pulse the source's resp_valid for exactly 1 cycle on the next cycle, and go to IDLE.
REQ-034 Writes SHALL produce no resp_valid pulse.
REQ-035 Read latency: accept at T, mem_req_valid at T+1; with mem_req_ready at T+1 and mem_resp_valid at T+k, resp_valid SHALL be high at T+k+1.
REQ-036 mem_resp_valid outside RESP SHALL be ignored.
REQ-037 A req_valid deasserted before grant SHALL have no effect.
REQ-038 resp_data SHALL hold its last value when no resp_valid is asserted.

Reset
REQ-039 While reset is low: state = IDLE, dc_streak = 0, and all outputs including resp_data SHALL be 0, asynchronously.
REQ-040 Reset mid-transaction SHALL abandon the transaction; a later mem_resp_valid SHALL be ignored.

Verification
REQ-041 DCache read addr 0x10 (memory ready at once, response 3 cycles later, data 0xA5..) -> dc_req_ready pulse at T, mem_req_valid at T+1, dc_resp_valid at T+5 with matching data, ic_resp_valid stays 0.
REQ-042 DCache write with mask 0x000F and mem_req_ready held low for 4 cycles -> mem_req_* stable for all 4 cycles, return to IDLE after the handshake, no resp_valid pulse.
REQ-043 ic_req_valid and dc_req_valid both held high -> grant order D,D,D,I,D,D,D,I; dc_streak clears after each I grant.
REQ-044 Spurious mem_resp_valid in IDLE and in REQ -> no resp_valid pulse, no state change.
REQ-045 reset asserted in RESP, then a mem_resp_valid arrives -> all outputs 0 immediately, no resp_valid after reset is released, next request served normally.
